// File: rtl/uart_tx_serializer_if.sv
// Transmit-side handshake bundle between the read-flow controller (master)
// and the serializer (slave): request/word in, serial line plus done/busy out.
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  TxData;
    logic [DATA_WIDTH-1:0] DataIn;
    logic                  SerialOut;
    logic                  TxDone;
    logic                  TxBusy;

    modport master (
        output TxData,
        output DataIn,
        input  SerialOut,
        input  TxDone,
        input  TxBusy
    );

    modport slave (
        input  TxData,
        input  DataIn,
        output SerialOut,
        output TxDone,
        output TxBusy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Asynchronous-serial frame transmitter closing a four-phase TxData/TxDone handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    uart_tx_serializer_if.slave   tx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic                  serial_reg, serial_next;
    logic                  done_reg, done_next;
    logic                  busy_reg, busy_next;
    logic                  bit_end;
`ifdef UART_TX_PARITY_EN
    logic                  parity_reg, parity_next;
`endif

    assign bit_end = (cnt_reg == CNT_LAST);

    // Outputs are registered from the next state so the line changes on the
    // same edge that enters a state (start bit appears on the accepting edge).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            shift_reg  <= '0;
            serial_reg <= 1'b1;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            shift_reg  <= shift_next;
            serial_reg <= serial_next;
            done_reg   <= done_next;
            busy_reg   <= busy_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (tx.TxData) begin
                    state_next = START;
                    shift_next = tx.DataIn;
                    cnt_next   = '0;
                    idx_next   = '0;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^tx.DataIn;
`endif
                end
            end
            START: begin
                cnt_next = bit_end ? '0 : cnt_reg + CNT_W'(1);
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                cnt_next = bit_end ? '0 : cnt_reg + CNT_W'(1);
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    idx_next   = idx_reg + IDX_W'(1);
                    if (idx_reg == IDX_LAST) begin
                        idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                cnt_next = bit_end ? '0 : cnt_reg + CNT_W'(1);
                if (bit_end) state_next = STOP;
            end
`endif
            STOP: begin
                cnt_next = bit_end ? '0 : cnt_reg + CNT_W'(1);
                if (bit_end) state_next = DONE;
            end
            DONE: begin
                if (!tx.TxData) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        serial_next = 1'b1;
        done_next   = 1'b0;
        busy_next   = (state_next != IDLE);
        case (state_next)
            START:  serial_next = 1'b0;
            DATA:   serial_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY: serial_next = parity_next;
`endif
            DONE:   done_next   = 1'b1;
            default: ;
        endcase
    end

    assign tx.SerialOut = serial_reg;
    assign tx.TxDone    = done_reg;
    assign tx.TxBusy    = busy_reg;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized scoreboard bench: the driver queues expected words, a negedge
// monitor reconstructs each frame from a bit-level reference and checks it.
module tb_uart_tx_serializer;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txd [2];
    logic [7:0] din [2];
    logic       ser_w [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic       end_req = 1'b0;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_tx_serializer_if #(.DATA_WIDTH(8)) bus0 ();
    uart_tx_serializer_if #(.DATA_WIDTH(8)) bus1 ();

    uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut0 (
        .Clk(clk), .Reset(rst), .tx(bus0)
    );
    uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .Clk(clk), .Reset(rst), .tx(bus1)
    );

    assign bus0.TxData = txd[0];
    assign bus0.DataIn = din[0];
    assign bus1.TxData = txd[1];
    assign bus1.DataIn = din[1];
    assign ser_w[0]  = bus0.SerialOut;
    assign ser_w[1]  = bus1.SerialOut;
    assign busy_w[0] = bus0.TxBusy;
    assign busy_w[1] = bus1.TxBusy;
    assign done_w[0] = bus0.TxDone;
    assign done_w[1] = bus1.TxDone;

    // Frame bit k: start, data LSB first, optional even parity, stop.
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0)      return 1'b0;
        if (k == NB - 1) return 1'b1;
        if (k <= 8)      return ((d >> (k - 1)) & 8'd1) != 8'd0;
        return ($countones(d) % 2) == 1;
    endfunction

    task automatic chk(input string name, input int u, input int i,
                       input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s unit=%0d idx=%0d {ser,busy,done} got=%b expected=%b",
                      name, u, i, got, exp);
    endtask

    // Monitor state per unit: 0 idle, 1 in frame, 2 done held, 3 unexpected frame.
    int         phase [2];
    int         idx   [2];
    logic [7:0] cur   [2];
    logic       tdl   [2];

    initial begin
        for (int u = 0; u < 2; u++) begin
            phase[u] = 0; idx[u] = 0; cur[u] = 8'h00; tdl[u] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (end_req) begin
            chk("queues_drained", 0, 0,
                {q0.size() == 0, q1.size() == 0, phase[0] == 0 && phase[1] == 0}, 3'b111);
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end
        for (int u = 0; u < 2; u++) begin
            logic [2:0] obs;
            int c;
            int tot;
            obs = {ser_w[u], busy_w[u], done_w[u]};
            c   = (u == 0) ? 4 : 1;
            tot = NB * c;
            if (rst) begin
                chk("reset_state", u, idx[u], obs, 3'b100);
                phase[u] = 0;
            end else begin
                if (phase[u] == 0) begin
                    if (busy_w[u]) begin
                        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                            chk("unexpected_frame", u, 0, obs, 3'b100);
                            phase[u] = 3;
                        end else begin
                            cur[u]   = (u == 0) ? q0.pop_front() : q1.pop_front();
                            phase[u] = 1;
                            idx[u]   = 0;
                        end
                    end else begin
                        chk("idle", u, 0, obs, 3'b100);
                    end
                end
                if (phase[u] == 1) begin
                    if (idx[u] < tot) begin
                        chk("frame_bit", u, idx[u], obs,
                            {exp_bit(cur[u], idx[u] / c), 1'b1, 1'b0});
                    end else begin
                        chk("done_rise", u, idx[u], obs, 3'b111);
                        phase[u] = 2;
                    end
                    idx[u]++;
                end else if (phase[u] == 2) begin
                    if (tdl[u]) begin
                        chk("done_hold", u, idx[u], obs, 3'b111);
                    end else begin
                        chk("done_release", u, idx[u], obs, 3'b100);
                        phase[u] = 0;
                    end
                    idx[u]++;
                end else if (phase[u] == 3) begin
                    if (!busy_w[u]) phase[u] = 0;
                end
            end
            tdl[u] = txd[u];
        end
    end

    task automatic push(input int u, input logic [7:0] d);
        if (u == 0) q0.push_back(d);
        else        q1.push_back(d);
    endtask

    task automatic send(input int u, input logic [7:0] d, input bit pulse,
                        input logic [7:0] mid, input int hold);
        int lim;
        int c;
        lim = 0;
        c   = (u == 0) ? 4 : 1;
        @(posedge clk); #1;
        txd[u] = 1'b1;
        din[u] = d;
        push(u, d);
        @(posedge clk); #1;
        din[u] = mid;
        if (pulse) txd[u] = 1'b0;
        while (!done_w[u] && lim < NB * c + 20) begin
            @(posedge clk); #1;
            lim++;
        end
        if (!pulse) begin
            repeat (hold) @(posedge clk);
            #1;
            txd[u] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        txd[0] = 1'b0; txd[1] = 1'b0;
        din[0] = 8'h00; din[1] = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);

        send(0, 8'hA5, 1'b0, 8'h5A, 3);
        send(0, 8'h07, 1'b0, 8'hF8, 2);
        send(0, 8'h3C, 1'b1, 8'hFF, 0);
        send(1, 8'h01, 1'b0, 8'hFE, 3);

        // Abort a frame with reset in the middle of its data bits.
        @(posedge clk); #1;
        txd[0] = 1'b1;
        din[0] = 8'($urandom);
        push(0, din[0]);
        repeat (18) @(posedge clk);
        #1 rst = 1'b1;
        txd[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        send(0, 8'($urandom), 1'b0, 8'($urandom), 1);

        for (int i = 0; i < 12; i++) begin
            send(int'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 8'($urandom), int'($urandom_range(0, 4)));
        end
        repeat (3) @(posedge clk);
        #1 end_req = 1'b1;
        repeat (5) @(posedge clk);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule
